// File: rtl/conv_ctrl_pkg.sv
// Shared types and defaults for the fused 3x3 -> 1x1 convolution pipeline controller.
// Both FSM encodings and the PE strobe masks live here so the top and reader agree.
package conv_ctrl_pkg;

    localparam int DEF_NUM_PE        = 16;
    localparam int DEF_WORDS_PER_PIX = 4;
    localparam int DEF_OFM_PIXELS    = 3136;
    localparam int DEF_ADDR_W        = 32;

    localparam logic [15:0] ALL_PE_MASK    = 16'hFFFF;
    localparam logic [3:0]  ALL_PE1X1_MASK = 4'hF;

    typedef enum logic [2:0] {
        W_IDLE,
        W_RUN,
        W_FIN,
        W_DRAIN,
        W_CLR,
        W_FLUSH
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_READ,
        R_LAST
    } r_state_t;

    // Width of a counter that indexes n items; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_ctrl_reader.sv
// Stage-2 reader: pulls each complete pixel out of the inter-stage BRAM into the 1x1 cluster.
// Starts a pixel only when the writer's registered pointer shows a whole pixel is stored.
module conv_ctrl_reader
    import conv_ctrl_pkg::*;
#(
    parameter int WORDS_PER_PIX = DEF_WORDS_PER_PIX,
    parameter int ADDR_W        = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] wr_ptr_i,
    input  logic              flush_req_i,
    output logic [ADDR_W-1:0] addr_rd_o,
    output logic [ADDR_W-1:0] addr_w_o,
    output logic [3:0]        pe_reset_o,
    output logic              valid_o,
    output logic              flush_ack_o
);

    localparam int             J_W    = cnt_width(WORDS_PER_PIX);
    localparam logic [J_W-1:0] J_LAST = J_W'(WORDS_PER_PIX - 1);

    r_state_t          state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [J_W-1:0]    j_q, j_d;
    logic              valid_q, valid_d;
    logic              pix_ready;

    // Unsigned difference tolerates pointer wrap.
    assign pix_ready = (wr_ptr_i - rd_ptr_q) >= ADDR_W'(WORDS_PER_PIX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= R_IDLE;
            rd_ptr_q <= '0;
            j_q      <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            j_q      <= j_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        j_d      = j_q;
        valid_d  = (state_q == R_LAST);
        case (state_q)
            R_IDLE: begin
                if (pix_ready) begin
                    state_d = R_READ;
                    j_d     = '0;
                end
            end
            R_READ: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                j_d      = j_q + 1'b1;
                if (j_q == J_LAST) begin
                    state_d = R_LAST;
                end
            end
            R_LAST: begin
                state_d = R_IDLE;
            end
            default: begin
                state_d = R_IDLE;
            end
        endcase
        if (clr_i) begin
            rd_ptr_d = '0;
        end
    end

    always_comb begin
        addr_rd_o  = '0;
        addr_w_o   = '0;
        pe_reset_o = '0;
        if (state_q == R_READ) begin
            addr_rd_o  = rd_ptr_q;
            addr_w_o   = ADDR_W'(j_q);
            pe_reset_o = (j_q == '0) ? ALL_PE1X1_MASK : 4'h0;
        end
    end

    // The layer is finished only once the last 1x1 result has been flagged.
    assign valid_o     = valid_q;
    assign flush_ack_o = flush_req_i && (state_q == R_IDLE) &&
                         (rd_ptr_q == wr_ptr_i) && !valid_q;

endmodule

// File: rtl/conv_pipe_ctrl.sv
// Sequencer for the fused 3x3-CONV -> 1x1-CONV pipeline: stage-1 writer FSM plus layer
// bookkeeping (done/busy/overrun); the stage-2 reader lives in conv_ctrl_reader.
module conv_pipe_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int NUM_PE        = DEF_NUM_PE,
    parameter int WORDS_PER_PIX = DEF_WORDS_PER_PIX,
    parameter int OFM_PIXELS    = DEF_OFM_PIXELS,
    parameter int ADDR_W        = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              done_window,
    output logic [NUM_PE-1:0] PE_finish,
    output logic [NUM_PE-1:0] PE_reset,
    output logic [1:0]        control_mux,
    output logic              wr_en_next,
    output logic [ADDR_W-1:0] addr_ram_next_wr,
    output logic [ADDR_W-1:0] addr_ram_next_rd,
    output logic [ADDR_W-1:0] addr_w_n_state,
    output logic [3:0]        PE_reset_n_state,
    output logic              n_state_valid,
    output logic              busy,
    output logic              done,
    output logic              err_overrun
);

    localparam int             K_W       = cnt_width(WORDS_PER_PIX);
    localparam logic [K_W-1:0] K_LAST    = K_W'(WORDS_PER_PIX - 1);
    localparam logic [31:0]    PIX_TOTAL = 32'(OFM_PIXELS);

    w_state_t          w_state_q, w_state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]       pix_cnt_q, pix_cnt_d;
    logic [K_W-1:0]    k_q, k_d;
    logic              err_q, err_d;
    logic              rd_clr;
    logic              flush_req;
    logic              flush_ack;

    assign rd_clr    = (w_state_q == W_IDLE) && start;
    assign flush_req = (w_state_q == W_FLUSH);

    conv_ctrl_reader #(
        .WORDS_PER_PIX (WORDS_PER_PIX),
        .ADDR_W        (ADDR_W)
    ) u_reader (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (rd_clr),
        .wr_ptr_i    (wr_ptr_q),
        .flush_req_i (flush_req),
        .addr_rd_o   (addr_ram_next_rd),
        .addr_w_o    (addr_w_n_state),
        .pe_reset_o  (PE_reset_n_state),
        .valid_o     (n_state_valid),
        .flush_ack_o (flush_ack)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            wr_ptr_q  <= '0;
            pix_cnt_q <= '0;
            k_q       <= '0;
            err_q     <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            wr_ptr_q  <= wr_ptr_d;
            pix_cnt_q <= pix_cnt_d;
            k_q       <= k_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        wr_ptr_d  = wr_ptr_q;
        pix_cnt_d = pix_cnt_q;
        k_d       = k_q;
        // A window completion outside W_RUN is lost; remember that it happened.
        err_d     = err_q | (done_window && (w_state_q != W_RUN));
        case (w_state_q)
            W_IDLE: begin
                if (start) begin
                    w_state_d = W_RUN;
                    wr_ptr_d  = '0;
                    pix_cnt_d = '0;
                end
            end
            W_RUN: begin
                if (done_window) begin
                    w_state_d = W_FIN;
                end
            end
            W_FIN: begin
                w_state_d = W_DRAIN;
                k_d       = '0;
            end
            W_DRAIN: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                k_d      = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    w_state_d = W_CLR;
                end
            end
            W_CLR: begin
                pix_cnt_d = pix_cnt_q + 32'd1;
                w_state_d = (pix_cnt_d == PIX_TOTAL) ? W_FLUSH : W_RUN;
            end
            W_FLUSH: begin
                if (flush_ack) begin
                    w_state_d = W_IDLE;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    always_comb begin
        PE_finish        = '0;
        PE_reset         = '0;
        control_mux      = 2'd0;
        wr_en_next       = 1'b0;
        addr_ram_next_wr = '0;
        case (w_state_q)
            W_FIN: begin
                PE_finish = NUM_PE'(ALL_PE_MASK);
            end
            W_DRAIN: begin
                control_mux      = 2'(k_q);
                // Suppress the BRAM write in the cycle a reset is being taken.
                wr_en_next       = !reset;
                addr_ram_next_wr = wr_ptr_q;
            end
            W_CLR: begin
                PE_reset = NUM_PE'(ALL_PE_MASK);
            end
            default: begin
            end
        endcase
    end

    assign busy        = (w_state_q != W_IDLE);
    assign done        = flush_req && flush_ack;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_conv_pipe_ctrl.sv
// Bench for conv_pipe_ctrl: per-cycle output traces compared with a timing model
// derived from the pipeline's latency rules (window -> writes -> reads -> result).
module tb_conv_pipe_ctrl;

    localparam int OFM_T = 3;
    localparam int AW    = 32;
    localparam int MAXC  = 600;
    localparam int OW    = 139;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          done_window;
    logic [15:0]   PE_finish;
    logic [15:0]   PE_reset;
    logic [1:0]    control_mux;
    logic          wr_en_next;
    logic [AW-1:0] addr_ram_next_wr;
    logic [AW-1:0] addr_ram_next_rd;
    logic [AW-1:0] addr_w_n_state;
    logic [3:0]    PE_reset_n_state;
    logic          n_state_valid;
    logic          busy;
    logic          done;
    logic          err_overrun;

    conv_pipe_ctrl #(
        .NUM_PE        (16),
        .WORDS_PER_PIX (4),
        .OFM_PIXELS    (OFM_T),
        .ADDR_W        (AW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .done_window      (done_window),
        .PE_finish        (PE_finish),
        .PE_reset         (PE_reset),
        .control_mux      (control_mux),
        .wr_en_next       (wr_en_next),
        .addr_ram_next_wr (addr_ram_next_wr),
        .addr_ram_next_rd (addr_ram_next_rd),
        .addr_w_n_state   (addr_w_n_state),
        .PE_reset_n_state (PE_reset_n_state),
        .n_state_valid    (n_state_valid),
        .busy             (busy),
        .done             (done),
        .err_overrun      (err_overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit          st_stim[MAXC];
    bit          dw_stim[MAXC];
    logic [OW-1:0] act_vec[MAXC];
    logic [OW-1:0] exp_vec[MAXC];
    logic [OW-1:0] exp_msk[MAXC];

    bit e_fin[MAXC], e_clr[MAXC], e_wr[MAXC], e_rd[MAXC], e_nrst[MAXC];
    bit e_val[MAXC], e_busy[MAXC], e_done[MAXC], e_err[MAXC];
    int e_wa[MAXC], e_mux[MAXC], e_ra[MAXC], e_wn[MAXC];

    function automatic logic [OW-1:0] pack_fields(
        logic [15:0] fin, logic [15:0] clr, logic [1:0] mux, logic wr,
        logic [31:0] wa, logic [31:0] ra, logic [31:0] wn, logic [3:0] nrst,
        logic val, logic bsy, logic dn, logic err);
        return {fin, clr, mux, wr, wa, ra, wn, nrst, val, bsy, dn, err};
    endfunction

    function automatic logic [OW-1:0] pack_out();
        return pack_fields(PE_finish, PE_reset, control_mux, wr_en_next,
                           addr_ram_next_wr, addr_ram_next_rd, addr_w_n_state,
                           PE_reset_n_state, n_state_valid, busy, done, err_overrun);
    endfunction

    task automatic clear_stim();
        for (int c = 0; c < MAXC; c++) begin
            st_stim[c] = 1'b0;
            dw_stim[c] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        start       = 1'b0;
        done_window = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Timing model: an accepted window at t gives finish at t+1, writes t+2..t+5,
    // clear at t+6; the reader starts one cycle after both the pixel is stored and
    // the reader is free, reads 4 words, and flags its result 5 cycles after starting.
    task automatic build_model(input int len);
        bit active    = 1'b0;
        int ready_at  = 0;
        int pix       = 0;
        int rfree     = 0;
        int done_at   = -1;
        int err_from  = -1;
        int t;
        int r;
        for (int c = 0; c < MAXC; c++) begin
            e_fin[c] = 0; e_clr[c] = 0; e_wr[c] = 0; e_rd[c] = 0; e_nrst[c] = 0;
            e_val[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_err[c] = 0;
            e_wa[c] = 0; e_mux[c] = 0; e_ra[c] = 0; e_wn[c] = 0;
        end
        for (int c = 0; c < len; c++) begin
            if (active && done_at >= 0 && c > done_at) active = 1'b0;
            e_busy[c] = active;
            if (dw_stim[c]) begin
                if (active && c >= ready_at && pix < OFM_T) begin
                    t = c;
                    e_fin[t+1] = 1;
                    for (int k = 0; k < 4; k++) begin
                        e_wr[t+2+k]  = 1;
                        e_wa[t+2+k]  = 4 * pix + k;
                        e_mux[t+2+k] = k;
                    end
                    e_clr[t+6] = 1;
                    r = (((t + 6) > rfree) ? (t + 6) : rfree) + 1;
                    for (int j = 0; j < 4; j++) begin
                        e_rd[r+j] = 1;
                        e_ra[r+j] = 4 * pix + j;
                        e_wn[r+j] = j;
                    end
                    e_nrst[r]  = 1;
                    e_val[r+5] = 1;
                    rfree      = r + 5;
                    pix++;
                    ready_at = t + 7;
                    if (pix == OFM_T) begin
                        done_at = r + 6;
                        e_done[done_at] = 1;
                    end
                end else if (err_from < 0) begin
                    err_from = c + 1;
                end
            end
            if (!active && st_stim[c]) begin
                active   = 1'b1;
                ready_at = c + 1;
                pix      = 0;
                done_at  = -1;
            end
            e_err[c] = (err_from >= 0) && (c >= err_from);
        end
        for (int c = 0; c < len; c++) begin
            exp_vec[c] = pack_fields(e_fin[c] ? 16'hFFFF : 16'h0, e_clr[c] ? 16'hFFFF : 16'h0,
                                     2'(e_mux[c]), e_wr[c], 32'(e_wa[c]), 32'(e_ra[c]),
                                     32'(e_wn[c]), e_nrst[c] ? 4'hF : 4'h0,
                                     e_val[c], e_busy[c], e_done[c], e_err[c]);
            exp_msk[c] = pack_fields(16'hFFFF, 16'hFFFF, e_wr[c] ? 2'b11 : 2'b00, 1'b1,
                                     e_wr[c] ? 32'hFFFF_FFFF : 32'h0,
                                     e_rd[c] ? 32'hFFFF_FFFF : 32'h0,
                                     e_rd[c] ? 32'hFFFF_FFFF : 32'h0,
                                     4'hF, 1'b1, 1'b1, 1'b1, 1'b1);
        end
    endtask

    // Cycle 0 is the cycle in which st_stim[0] is presented.
    task automatic run_stim(input int len);
        for (int c = 0; c < len; c++) begin
            start       = st_stim[c];
            done_window = dw_stim[c];
            @(negedge clk);
            act_vec[c] = pack_out();
            @(posedge clk);
            #1;
        end
        start       = 1'b0;
        done_window = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        start       = 1'b1;
        done_window = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (pack_out() !== '0) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %h required 0", i, pack_out());
            end
            @(posedge clk);
            #1;
        end
        reset       = 1'b0;
        start       = 1'b0;
        done_window = 1'b0;
        @(negedge clk);
        n_tests++;
        if (pack_out() !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got %h required 0", pack_out());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_pixel();
        clear_stim();
        st_stim[0]  = 1;
        dw_stim[10] = 1;
        do_reset();
        build_model(40);
        run_stim(40);
        for (int c = 0; c < 40; c++) begin
            n_tests++;
            if ((act_vec[c] & exp_msk[c]) !== (exp_vec[c] & exp_msk[c])) begin
                n_fail++;
                $display("FAIL single_pixel cycle %0d: got %h required %h", c,
                         act_vec[c] & exp_msk[c], exp_vec[c] & exp_msk[c]);
            end
        end
        n_tests++;
        if (act_vec[22][3] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pixel_valid22: got %b required 1", act_vec[22][3]);
        end
    endtask

    task automatic test_three_pixels();
        int nval = 0;
        int ndone = 0;
        clear_stim();
        st_stim[0]  = 1;
        dw_stim[10] = 1;
        dw_stim[50] = 1;
        dw_stim[90] = 1;
        do_reset();
        build_model(160);
        run_stim(160);
        for (int c = 0; c < 160; c++) begin
            n_tests++;
            if ((act_vec[c] & exp_msk[c]) !== (exp_vec[c] & exp_msk[c])) begin
                n_fail++;
                $display("FAIL three_pixels cycle %0d: got %h required %h", c,
                         act_vec[c] & exp_msk[c], exp_vec[c] & exp_msk[c]);
            end
            nval  += int'(act_vec[c][3]);
            ndone += int'(act_vec[c][1]);
        end
        n_tests++;
        if (nval != 3 || ndone != 1 || act_vec[159][0] !== 1'b0) begin
            n_fail++;
            $display("FAIL three_pixels_totals: valid=%0d done=%0d err=%b required 3 1 0",
                     nval, ndone, act_vec[159][0]);
        end
    endtask

    task automatic test_overrun();
        clear_stim();
        st_stim[0]  = 1;
        dw_stim[10] = 1;
        dw_stim[13] = 1;
        dw_stim[20] = 1;
        dw_stim[40] = 1;
        dw_stim[41] = 1;
        dw_stim[60] = 1;
        do_reset();
        build_model(140);
        run_stim(140);
        for (int c = 0; c < 140; c++) begin
            n_tests++;
            if ((act_vec[c] & exp_msk[c]) !== (exp_vec[c] & exp_msk[c])) begin
                n_fail++;
                $display("FAIL overrun cycle %0d: got %h required %h", c,
                         act_vec[c] & exp_msk[c], exp_vec[c] & exp_msk[c]);
            end
        end
        n_tests++;
        if (act_vec[139][0] !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: got %b required 1", act_vec[139][0]);
        end
    endtask

    task automatic test_back_to_back();
        clear_stim();
        st_stim[0]  = 1;
        dw_stim[1]  = 1;
        dw_stim[8]  = 1;
        dw_stim[15] = 1;
        do_reset();
        build_model(60);
        run_stim(60);
        for (int c = 0; c < 60; c++) begin
            n_tests++;
            if ((act_vec[c] & exp_msk[c]) !== (exp_vec[c] & exp_msk[c])) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %h required %h", c,
                         act_vec[c] & exp_msk[c], exp_vec[c] & exp_msk[c]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int ndone = 0;
        clear_stim();
        st_stim[0]  = 1;
        st_stim[20] = 1;
        st_stim[45] = 1;
        dw_stim[10] = 1;
        dw_stim[30] = 1;
        dw_stim[50] = 1;
        do_reset();
        build_model(100);
        run_stim(100);
        for (int c = 0; c < 100; c++) begin
            n_tests++;
            if ((act_vec[c] & exp_msk[c]) !== (exp_vec[c] & exp_msk[c])) begin
                n_fail++;
                $display("FAIL start_busy cycle %0d: got %h required %h", c,
                         act_vec[c] & exp_msk[c], exp_vec[c] & exp_msk[c]);
            end
            ndone += int'(act_vec[c][1]);
        end
        n_tests++;
        if (ndone != 1 || act_vec[99][2] !== 1'b0) begin
            n_fail++;
            $display("FAIL start_busy_done: done=%0d busy=%b required 1 0", ndone, act_vec[99][2]);
        end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int c = 0; c < 14; c++) begin
            start       = (c == 0);
            done_window = (c == 10);
            if (c == 13) begin
                @(negedge clk);
                n_tests++;
                if (wr_en_next !== 1'b1 || addr_ram_next_wr !== 32'd1 || control_mux !== 2'd1) begin
                    n_fail++;
                    $display("FAIL mid_drain_k1: wr=%b addr=%0d mux=%0d required 1 1 1",
                             wr_en_next, addr_ram_next_wr, control_mux);
                end
            end
            @(posedge clk);
            #1;
        end
        start       = 1'b0;
        done_window = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        n_tests++;
        if (wr_en_next !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cycle_write: got %b required 0", wr_en_next);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (pack_out() !== '0) begin
            n_fail++;
            $display("FAIL after_mid_reset: got %h required 0", pack_out());
        end
        @(posedge clk);
        #1;
        clear_stim();
        st_stim[0]  = 1;
        dw_stim[10] = 1;
        dw_stim[20] = 1;
        dw_stim[30] = 1;
        build_model(80);
        run_stim(80);
        for (int c = 0; c < 80; c++) begin
            n_tests++;
            if ((act_vec[c] & exp_msk[c]) !== (exp_vec[c] & exp_msk[c])) begin
                n_fail++;
                $display("FAIL restart cycle %0d: got %h required %h", c,
                         act_vec[c] & exp_msk[c], exp_vec[c] & exp_msk[c]);
            end
        end
    endtask

    task automatic test_random();
        int dens;
        for (int it = 0; it < 4; it++) begin
            dens = 3 + 4 * it;
            clear_stim();
            st_stim[0] = 1;
            for (int c = 1; c < 340; c++) begin
                st_stim[c] = ($urandom_range(0, 39) == 0);
                dw_stim[c] = ($urandom_range(0, dens) == 0);
            end
            do_reset();
            build_model(400);
            run_stim(400);
            for (int c = 0; c < 400; c++) begin
                n_tests++;
                if ((act_vec[c] & exp_msk[c]) !== (exp_vec[c] & exp_msk[c])) begin
                    n_fail++;
                    $display("FAIL random it%0d cycle %0d: got %h required %h", it, c,
                             act_vec[c] & exp_msk[c], exp_vec[c] & exp_msk[c]);
                end
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        done_window = 1'b0;
        test_reset();
        test_single_pixel();
        test_three_pixels();
        test_overrun();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_pipe_ctrl.md
Name: conv_pipe_ctrl

Overview:
- Sequences the fused 3x3-CONV -> 1x1-CONV pipeline. The 3x3 datapath is the 16-PE cluster fed by the address generator. The 1x1 datapath is the 4-PE cluster fed from the inter-stage BRAM.
- Stage 1 (writer FSM): on each finished 3x3 window it finalises the 16 PEs, drains 16 ReLU6 bytes into the inter-stage BRAM as four 32-bit words, then clears the PEs.
- Stage 2 (reader FSM): once a full pixel (4 words) is in the BRAM, it streams that pixel plus matching 1x1 weights into the 1x1 cluster and flags its result.

Parameters:
- NUM_PE, 16, 3x3 PEs per cluster; one output channel each.
- WORDS_PER_PIX, 4, 32-bit words per output pixel (NUM_PE/4).
- OFM_PIXELS, 3136, output pixels per layer (56x56).
- ADDR_W, 32, inter-stage BRAM address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  1-cycle pulse; begins a layer; ignored unless idle
- done_window  in  1  address generator: current 3x3 window fully accumulated
- PE_finish  out  16  finalise strobe to 3x3 PEs
- PE_reset  out  16  accumulator clear to 3x3 PEs
- control_mux  out  2  selects byte group (4 PEs) to pack into a word
- wr_en_next  out  1  inter-stage BRAM write enable
- addr_ram_next_wr  out  ADDR_W  inter-stage BRAM write address
- addr_ram_next_rd  out  ADDR_W  inter-stage BRAM read address
- addr_w_n_state  out  ADDR_W  1x1 weight BRAM read address
- PE_reset_n_state  out  4  accumulator clear to 1x1 PEs
- n_state_valid  out  1  1x1 outputs (OFM_0..3_n_state) valid this cycle
- busy  out  1  layer in progress
- done  out  1  1-cycle pulse; layer fully processed by both stages
- err_overrun  out  1  sticky: done_window arrived while not in W_RUN

Behaviour:
- Reset state: every output is 0; both FSMs idle; wr_ptr = rd_ptr = pix_cnt = 0; err_overrun cleared. A reset mid-layer aborts both FSMs immediately; no BRAM write occurs in the reset cycle.

Writer FSM: W_IDLE -> W_RUN -> W_FIN -> W_DRAIN -> W_CLR -> (W_RUN | W_FLUSH) -> W_IDLE.
- W_IDLE: on start -> W_RUN. wr_ptr, rd_ptr and pix_cnt load 0 there; busy=1 from the next cycle.
- W_RUN: waits for done_window. done_window=1 -> W_FIN.
- W_FIN: one cycle; PE_finish=16'hFFFF.
- W_DRAIN: exactly WORDS_PER_PIX cycles, k = 0..3.
  - control_mux=k, wr_en_next=1, addr_ram_next_wr = wr_ptr.
  - wr_ptr increments after each write.
- W_CLR: one cycle; PE_reset=16'hFFFF; pix_cnt++. Next state is W_FLUSH if the new pix_cnt == OFM_PIXELS, else W_RUN.
- W_FLUSH: waits until the reader is idle and rd_ptr == wr_ptr. Then pulses done, drops busy, -> W_IDLE.
- done_window seen in any writer state other than W_RUN: sets err_overrun and the pulse is dropped. err_overrun is cleared only by reset.
- Write-to-write spacing is fixed at 1 cycle; address wraps modulo 2^ADDR_W (never reached at defaults: max 12544 words).

Reader FSM: R_IDLE -> R_READ -> R_LAST -> R_IDLE.
- R_IDLE: start a pixel when (wr_ptr - rd_ptr) >= WORDS_PER_PIX. This uses the registered wr_ptr, so a word is read no earlier than the cycle after it is written (no read/write same-address hazard).
- R_READ: WORDS_PER_PIX cycles, j = 0..3.
  - addr_ram_next_rd = rd_ptr, addr_w_n_state = j; rd_ptr increments each cycle.
  - PE_reset_n_state=4'hF only at j=0.
- R_LAST: one cycle, covering the 1-cycle BRAM read latency; n_state_valid=1 the cycle after R_LAST.
- Read latency: data for address issued at cycle t is at the PE inputs at t+1. The PE accumulates at t+1's edge.
- Writer and reader run concurrently. The reader may start while the writer is in W_DRAIN for the next pixel. Counters are unsigned ADDR_W subtraction.

Decomposition:
- Package conv_ctrl_pkg holds:
  - w_state_t / r_state_t enums
  - WORDS_PER_PIX, NUM_PE, OFM_PIXELS defaults
  - ALL_PE_MASK = 16'hFFFF, ALL_PE1X1_MASK = 4'hF
- One sub-module, conv_ctrl_reader: the reader FSM, rd_ptr, read/weight address and PE_reset_n_state generation. Its inputs are wr_ptr and flush_req. The top holds the writer FSM and the done/err logic.

Test Plan:
- Single pixel, OFM_PIXELS=1: start, done_window at cycle 10.
  - Writer: PE_finish=FFFF at 11; wr_en_next 12-15 with addr 0..3 and control_mux 0..3; PE_reset=FFFF at 16.
  - Reader: read addr 0..3 at 17-20 with PE_reset_n_state=F at 17; n_state_valid at 22; done pulse at 22 or 23; busy=0 afterwards.
- OFM_PIXELS=3, done_window every 40 cycles -> 12 writes at addresses 0..11; 3 n_state_valid pulses; addr_w_n_state cycles 0..3 per pixel; err_overrun=0.
- done_window asserted during W_DRAIN -> err_overrun=1 and stays 1; pix_cnt is not advanced by that pulse.
- Back-to-back windows: done_window on the first cycle back in W_RUN -> no gap errors; reader lags the writer by ≥1 cycle per word.
- Reset asserted in the middle of W_DRAIN (at k=2) -> next cycle wr_en_next=0 and all outputs 0; a new start writes again from address 0.
- start pulsed while busy=1 -> ignored; write addresses stay continuous and done fires once.
